// File: rtl/bsg_manycore_sdr_token_uplink.sv
// Credit-based SDR uplink sender: core-side valid/ready in, registered io valid/data out,
// credits returned in decimated token pulses, with a RUN/DRAIN/OFF quiesce sequence.
module bsg_manycore_sdr_token_uplink #(
    parameter int unsigned width_p                         = 16,
    parameter int unsigned lg_fifo_depth_p                 = 3,
    parameter int unsigned lg_credit_to_token_decimation_p = 2,
    localparam int unsigned credit_width_lp                = lg_fifo_depth_p + 1
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic                       disable_i,
    input  logic                       v_i,
    input  logic [width_p-1:0]         data_i,
    output logic                       ready_o,
    output logic                       io_v_o,
    output logic [width_p-1:0]         io_data_o,
    input  logic                       io_token_i,
    output logic [credit_width_lp-1:0] credits_o,
    output logic                       idle_o,
    output logic                       overflow_o
);

    // One extra bit so a token landing on a full counter is visible before saturation.
    localparam int unsigned sum_width_lp = credit_width_lp + 1;
    localparam logic [credit_width_lp-1:0] full_credits_lp =
        credit_width_lp'(2 ** lg_fifo_depth_p);
    localparam logic [sum_width_lp-1:0] full_sum_lp =
        sum_width_lp'(2 ** lg_fifo_depth_p);
    localparam logic [sum_width_lp-1:0] token_credits_lp =
        sum_width_lp'(2 ** lg_credit_to_token_decimation_p);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_DRAIN = 2'd1,
        S_OFF   = 2'd2
    } state_e;

    state_e                     state_q;
    state_e                     state_d;
    logic [credit_width_lp-1:0] credits_q;
    logic [credit_width_lp-1:0] credits_d;
    logic [sum_width_lp-1:0]    credit_sum;
    logic                       credit_over;
    logic                       send;

    // Next-state and core-side ready; ready is held low while reset is asserted.
    always_comb begin
        state_d = state_q;
        ready_o = 1'b0;
        case (state_q)
            S_RUN: begin
                ready_o = reset_n_i & (credits_q != '0) & ~disable_i;
                if (disable_i) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (credits_q == full_credits_lp) begin
                    state_d = S_OFF;
                end
            end
            S_OFF: begin
                if (!disable_i) begin
                    state_d = S_RUN;
                end
            end
            default: state_d = S_RUN;
        endcase
    end

    assign send = v_i & ready_o;

    // Credit update: a send and a token in the same cycle both apply, then saturate.
    always_comb begin
        credit_sum  = sum_width_lp'(credits_q) - sum_width_lp'(send);
        credits_d   = credits_q;
        credit_over = 1'b0;
        if (io_token_i) begin
            credit_sum = credit_sum + token_credits_lp;
        end
        if (credit_sum > full_sum_lp) begin
            credit_over = 1'b1;
            credits_d   = full_credits_lp;
        end else begin
            credits_d   = credit_width_lp'(credit_sum);
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= S_RUN;
            credits_q  <= full_credits_lp;
            io_v_o     <= 1'b0;
            io_data_o  <= '0;
            overflow_o <= 1'b0;
        end else begin
            state_q    <= state_d;
            credits_q  <= credits_d;
            io_v_o     <= send;
            if (send) begin
                io_data_o <= data_i;
            end
            if (credit_over) begin
                overflow_o <= 1'b1;
            end
        end
    end

    assign credits_o = credits_q;
    assign idle_o    = (state_q == S_OFF);

endmodule

// File: tb/tb_bsg_manycore_sdr_token_uplink.sv
// Directed bench for the SDR token uplink: fill, token refill, simultaneous send/token,
// disable/drain sequence, credit overflow and reset mid-stream.
module tb_bsg_manycore_sdr_token_uplink;

    logic        clk;
    logic        reset_n_i;
    logic        disable_i;
    logic        v_i;
    logic [15:0] data_i;
    logic        ready_o;
    logic        io_v_o;
    logic [15:0] io_data_o;
    logic        io_token_i;
    logic [3:0]  credits_o;
    logic        idle_o;
    logic        overflow_o;

    int n_chk  = 0;
    int n_fail = 0;

    bsg_manycore_sdr_token_uplink #(
        .width_p                         (16),
        .lg_fifo_depth_p                 (3),
        .lg_credit_to_token_decimation_p (2)
    ) dut (
        .clk_i      (clk),
        .reset_n_i  (reset_n_i),
        .disable_i  (disable_i),
        .v_i        (v_i),
        .data_i     (data_i),
        .ready_o    (ready_o),
        .io_v_o     (io_v_o),
        .io_data_o  (io_data_o),
        .io_token_i (io_token_i),
        .credits_o  (credits_o),
        .idle_o     (idle_o),
        .overflow_o (overflow_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic test_reset();
        @(negedge clk);
        n_chk++; if (io_v_o !== 1'b0) begin n_fail++; $display("FAIL reset_io_v: got %b, expected 0", io_v_o); end
        n_chk++; if (io_data_o !== 16'h0000) begin n_fail++; $display("FAIL reset_io_data: got %h, expected 0000", io_data_o); end
        n_chk++; if (ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b, expected 0", ready_o); end
        n_chk++; if (credits_o !== 4'd8) begin n_fail++; $display("FAIL reset_credits: got %0d, expected 8", credits_o); end
        n_chk++; if (overflow_o !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b, expected 0", overflow_o); end
        n_chk++; if (idle_o !== 1'b0) begin n_fail++; $display("FAIL reset_idle: got %b, expected 0", idle_o); end
        reset_n_i = 1'b1;
    endtask

    // Stream with v_i held high and no tokens: 8 packets leave, then the sender stalls on 0x0009.
    task automatic test_fill();
        logic       exp_rdy;
        logic [3:0] exp_cr;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (k > 0 && k <= 8) begin
                n_chk++; if (io_v_o !== 1'b1) begin n_fail++; $display("FAIL fill_io_v k=%0d: got %b, expected 1", k, io_v_o); end
                n_chk++; if (io_data_o !== 16'(k)) begin n_fail++; $display("FAIL fill_io_data k=%0d: got %h, expected %h", k, io_data_o, 16'(k)); end
            end
            if (k == 9) begin
                n_chk++; if (io_v_o !== 1'b0) begin n_fail++; $display("FAIL fill_stall_io_v: got %b, expected 0", io_v_o); end
            end
            v_i    = 1'b1;
            data_i = (k < 8) ? 16'(k + 1) : 16'h0009;
            #1;
            exp_rdy = (k < 8);
            exp_cr  = (k < 8) ? 4'(8 - k) : 4'd0;
            n_chk++; if (ready_o !== exp_rdy) begin n_fail++; $display("FAIL fill_ready k=%0d: got %b, expected %b", k, ready_o, exp_rdy); end
            n_chk++; if (credits_o !== exp_cr) begin n_fail++; $display("FAIL fill_credits k=%0d: got %0d, expected %0d", k, credits_o, exp_cr); end
        end
        @(negedge clk);
        n_chk++; if (io_v_o !== 1'b0) begin n_fail++; $display("FAIL fill_end_io_v: got %b, expected 0", io_v_o); end
        n_chk++; if (io_data_o !== 16'h0008) begin n_fail++; $display("FAIL fill_end_hold: got %h, expected 0008", io_data_o); end
        n_chk++; if (ready_o !== 1'b0) begin n_fail++; $display("FAIL fill_end_ready: got %b, expected 0", ready_o); end
        n_chk++; if (credits_o !== 4'd0) begin n_fail++; $display("FAIL fill_end_credits: got %0d, expected 0", credits_o); end
    endtask

    // One token from zero credits releases exactly four packets.
    task automatic test_token();
        logic       exp_rdy;
        logic [3:0] exp_cr;
        io_token_i = 1'b1;
        #1;
        n_chk++; if (ready_o !== 1'b0) begin n_fail++; $display("FAIL token_pre_ready: got %b, expected 0", ready_o); end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            io_token_i = 1'b0;
            if (k > 0) begin
                n_chk++; if (io_v_o !== 1'b1) begin n_fail++; $display("FAIL token_io_v k=%0d: got %b, expected 1", k, io_v_o); end
                n_chk++; if (io_data_o !== 16'(8 + k)) begin n_fail++; $display("FAIL token_io_data k=%0d: got %h, expected %h", k, io_data_o, 16'(8 + k)); end
            end
            data_i = 16'(9 + k);
            #1;
            exp_rdy = (k < 4);
            exp_cr  = 4'(4 - k);
            n_chk++; if (ready_o !== exp_rdy) begin n_fail++; $display("FAIL token_ready k=%0d: got %b, expected %b", k, ready_o, exp_rdy); end
            n_chk++; if (credits_o !== exp_cr) begin n_fail++; $display("FAIL token_credits k=%0d: got %0d, expected %0d", k, credits_o, exp_cr); end
        end
        @(negedge clk);
        n_chk++; if (io_v_o !== 1'b0) begin n_fail++; $display("FAIL token_end_io_v: got %b, expected 0", io_v_o); end
        n_chk++; if (io_data_o !== 16'h000C) begin n_fail++; $display("FAIL token_end_hold: got %h, expected 000c", io_data_o); end
    endtask

    // Refill to 4, spend down to 1, then send and take a token in the same cycle: 1-1+4 = 4.
    task automatic test_send_and_token();
        io_token_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            io_token_i = (k == 3);
            data_i     = 16'(13 + k);
            #1;
            n_chk++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL snt_ready k=%0d: got %b, expected 1", k, ready_o); end
            n_chk++; if (credits_o !== 4'(4 - k)) begin n_fail++; $display("FAIL snt_credits k=%0d: got %0d, expected %0d", k, credits_o, 4'(4 - k)); end
        end
        @(negedge clk);
        io_token_i = 1'b0;
        v_i        = 1'b0;
        n_chk++; if (credits_o !== 4'd4) begin n_fail++; $display("FAIL snt_credits_after: got %0d, expected 4", credits_o); end
        n_chk++; if (io_v_o !== 1'b1) begin n_fail++; $display("FAIL snt_io_v: got %b, expected 1", io_v_o); end
        n_chk++; if (io_data_o !== 16'h0010) begin n_fail++; $display("FAIL snt_io_data: got %h, expected 0010", io_data_o); end
        n_chk++; if (overflow_o !== 1'b0) begin n_fail++; $display("FAIL snt_overflow: got %b, expected 0", overflow_o); end
    endtask

    // Disable with credits outstanding: DRAIN holds even after disable drops, until credits are full.
    task automatic test_disable_drain();
        io_token_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            io_token_i = 1'b0;
            v_i        = 1'b1;
            data_i     = 16'(17 + k);
            #1;
            n_chk++; if (credits_o !== 4'(8 - k)) begin n_fail++; $display("FAIL drain_fill_credits k=%0d: got %0d, expected %0d", k, credits_o, 4'(8 - k)); end
        end
        @(negedge clk);
        v_i       = 1'b0;
        disable_i = 1'b1;
        n_chk++; if (credits_o !== 4'd4) begin n_fail++; $display("FAIL drain_credits: got %0d, expected 4", credits_o); end
        n_chk++; if (io_data_o !== 16'h0014) begin n_fail++; $display("FAIL drain_last_data: got %h, expected 0014", io_data_o); end
        #1;
        n_chk++; if (ready_o !== 1'b0) begin n_fail++; $display("FAIL drain_disable_ready: got %b, expected 0", ready_o); end
        @(negedge clk);
        disable_i = 1'b0;
        #1;
        n_chk++; if (ready_o !== 1'b0) begin n_fail++; $display("FAIL drain_no_shortcut: got %b, expected 0", ready_o); end
        n_chk++; if (idle_o !== 1'b0) begin n_fail++; $display("FAIL drain_idle_early: got %b, expected 0", idle_o); end
        @(negedge clk);
        n_chk++; if (ready_o !== 1'b0) begin n_fail++; $display("FAIL drain_hold_ready: got %b, expected 0", ready_o); end
        io_token_i = 1'b1;
        @(negedge clk);
        io_token_i = 1'b0;
        n_chk++; if (credits_o !== 4'd8) begin n_fail++; $display("FAIL drain_refill: got %0d, expected 8", credits_o); end
        n_chk++; if (idle_o !== 1'b0) begin n_fail++; $display("FAIL drain_idle_pre: got %b, expected 0", idle_o); end
        @(negedge clk);
        n_chk++; if (idle_o !== 1'b1) begin n_fail++; $display("FAIL drain_off_idle: got %b, expected 1", idle_o); end
        n_chk++; if (ready_o !== 1'b0) begin n_fail++; $display("FAIL drain_off_ready: got %b, expected 0", ready_o); end
        @(negedge clk);
        n_chk++; if (idle_o !== 1'b0) begin n_fail++; $display("FAIL drain_run_idle: got %b, expected 0", idle_o); end
        n_chk++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL drain_run_ready: got %b, expected 1", ready_o); end
    endtask

    // Token on a full counter saturates and latches overflow.
    task automatic test_overflow();
        io_token_i = 1'b1;
        @(negedge clk);
        io_token_i = 1'b0;
        n_chk++; if (credits_o !== 4'd8) begin n_fail++; $display("FAIL ovf_credits: got %0d, expected 8", credits_o); end
        n_chk++; if (overflow_o !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b, expected 1", overflow_o); end
        @(negedge clk);
        n_chk++; if (overflow_o !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b, expected 1", overflow_o); end
    endtask

    // Reset while a packet is on io with 3 credits left.
    task automatic test_reset_midstream();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            v_i    = 1'b1;
            data_i = 16'(21 + k);
        end
        @(negedge clk);
        v_i = 1'b0;
        n_chk++; if (credits_o !== 4'd3) begin n_fail++; $display("FAIL rst_mid_credits: got %0d, expected 3", credits_o); end
        n_chk++; if (io_v_o !== 1'b1) begin n_fail++; $display("FAIL rst_mid_io_v: got %b, expected 1", io_v_o); end
        n_chk++; if (io_data_o !== 16'h0019) begin n_fail++; $display("FAIL rst_mid_io_data: got %h, expected 0019", io_data_o); end
        reset_n_i = 1'b0;
        #1;
        n_chk++; if (io_v_o !== 1'b0) begin n_fail++; $display("FAIL rst_async_io_v: got %b, expected 0", io_v_o); end
        n_chk++; if (ready_o !== 1'b0) begin n_fail++; $display("FAIL rst_async_ready: got %b, expected 0", ready_o); end
        @(negedge clk);
        reset_n_i = 1'b1;
        #1;
        n_chk++; if (credits_o !== 4'd8) begin n_fail++; $display("FAIL rst_rel_credits: got %0d, expected 8", credits_o); end
        n_chk++; if (overflow_o !== 1'b0) begin n_fail++; $display("FAIL rst_rel_overflow: got %b, expected 0", overflow_o); end
        n_chk++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL rst_rel_ready: got %b, expected 1", ready_o); end
        n_chk++; if (io_v_o !== 1'b0) begin n_fail++; $display("FAIL rst_rel_io_v: got %b, expected 0", io_v_o); end
    endtask

    initial begin
        reset_n_i  = 1'b0;
        disable_i  = 1'b0;
        v_i        = 1'b0;
        data_i     = 16'h0000;
        io_token_i = 1'b0;
        test_reset();
        test_fill();
        test_token();
        test_send_and_token();
        test_disable_drain();
        test_overflow();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
